// File: rtl/hht_pkg.sv
// Shared types and default sizes for the HHT CSR producer/consumer blocks.
package hht_pkg;

  localparam int unsigned N_DEFAULT      = 16;
  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned ADDR_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    STREAM,
    ROWPTR,
    FIN
  } state_t;

  // Bits needed to represent values 0..v-1 (minimum 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/csr_rc_counter.sv
// Row/column position tracker for the dense input stream.
module csr_rc_counter
  import hht_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned CW = clog2(N)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          col_inc,
  input  logic          col_clr,
  input  logic          row_inc,
  input  logic          row_clr,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          last_col,
  output logic          last_row
);

  // Counters; clear takes priority over increment.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      col <= '0;
      row <= '0;
    end else begin
      if (col_clr)      col <= '0;
      else if (col_inc) col <= col + CW'(1);
      if (row_clr)      row <= '0;
      else if (row_inc) row <= row + CW'(1);
    end
  end

  assign last_col = (col == CW'(N - 1));
  assign last_row = (row == CW'(N - 1));

endmodule

// File: rtl/csr_matrix_writer.sv
// Encodes a row-major dense N x N stream into CSR arrays in memory.
module csr_matrix_writer
  import hht_pkg::*;
#(
  parameter int unsigned N      = N_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] row_base,
  input  logic [ADDR_W-1:0] col_base,
  input  logic [ADDR_W-1:0] val_base,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr1_en,
  output logic [ADDR_W-1:0] wr1_addr,
  output logic [DATA_W-1:0] wr1_data,
  output logic              wr2_en,
  output logic [ADDR_W-1:0] wr2_addr,
  output logic [DATA_W-1:0] wr2_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] nnz
);

  localparam int unsigned CW = clog2(N);
  localparam int unsigned NW = clog2(N * N + 1);

  state_t            state;
  logic [ADDR_W-1:0] row_base_q;
  logic [ADDR_W-1:0] col_base_q;
  logic [ADDR_W-1:0] val_base_q;
  logic [NW-1:0]     nnz_q;
  logic [CW-1:0]     col;
  logic [CW-1:0]     row;
  logic              last_col;
  logic              last_row;
  logic              accept;
  logic              launch;

  assign accept = (state == STREAM) && in_valid && in_ready;
  assign launch = (state == IDLE) && start;
  assign nnz    = DATA_W'(nnz_q);

  csr_rc_counter #(.N(N), .CW(CW)) u_rc (
    .Clk      (Clk),
    .Rst      (Rst),
    .col_inc  (accept),
    .col_clr  (launch || (accept && last_col)),
    .row_inc  (state == ROWPTR),
    .row_clr  (launch),
    .col      (col),
    .row      (row),
    .last_col (last_col),
    .last_row (last_row)
  );

  // Encoder FSM with registered write ports and handshake.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      row_base_q <= '0;
      col_base_q <= '0;
      val_base_q <= '0;
      nnz_q      <= '0;
      in_ready   <= 1'b0;
      wr1_en     <= 1'b0;
      wr1_addr   <= '0;
      wr1_data   <= '0;
      wr2_en     <= 1'b0;
      wr2_addr   <= '0;
      wr2_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wr1_en <= 1'b0;
      wr2_en <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row_base_q <= row_base;
            col_base_q <= col_base;
            val_base_q <= val_base;
            nnz_q      <= '0;
            busy       <= 1'b1;
            state      <= INIT;
          end
        end
        INIT: begin
          wr1_en   <= 1'b1;
          wr1_addr <= row_base_q;
          wr1_data <= '0;
          in_ready <= 1'b1;
          state    <= STREAM;
        end
        STREAM: begin
          if (accept) begin
            if (in_data != '0) begin
              wr1_en   <= 1'b1;
              wr1_addr <= col_base_q + ADDR_W'(nnz_q);
              wr1_data <= DATA_W'(col);
              wr2_en   <= 1'b1;
              wr2_addr <= val_base_q + ADDR_W'(nnz_q);
              wr2_data <= in_data;
              nnz_q    <= nnz_q + NW'(1);
            end
            if (last_col) begin
              in_ready <= 1'b0;
              state    <= ROWPTR;
            end
          end
        end
        ROWPTR: begin
          wr1_en   <= 1'b1;
          wr1_addr <= row_base_q + ADDR_W'(row) + ADDR_W'(1);
          wr1_data <= DATA_W'(nnz_q);
          if (last_row) begin
            state <= FIN;
          end else begin
            in_ready <= 1'b1;
            state    <= STREAM;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
